// File: rtl/sb_pkg.sv
// Shared constants for the scoreboard issue stage: FU indices, ex_type codes, opcodes.
package sb_pkg;

  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_LSU = 2;
  localparam int NUM_FU = 3;

  localparam logic [5:0] EX_ADD   = 6'd0;
  localparam logic [5:0] EX_ADDI  = 6'd1;
  localparam logic [5:0] EX_SUB   = 6'd2;
  localparam logic [5:0] EX_AND   = 6'd3;
  localparam logic [5:0] EX_ANDI  = 6'd4;
  localparam logic [5:0] EX_OR    = 6'd5;
  localparam logic [5:0] EX_ORI   = 6'd6;
  localparam logic [5:0] EX_XOR   = 6'd7;
  localparam logic [5:0] EX_XORI  = 6'd8;
  localparam logic [5:0] EX_SLL   = 6'd9;
  localparam logic [5:0] EX_SLLI  = 6'd10;
  localparam logic [5:0] EX_SRL   = 6'd11;
  localparam logic [5:0] EX_SRLI  = 6'd12;
  localparam logic [5:0] EX_SRA   = 6'd13;
  localparam logic [5:0] EX_SRAI  = 6'd14;
  localparam logic [5:0] EX_SLT   = 6'd15;
  localparam logic [5:0] EX_SLTI  = 6'd16;
  localparam logic [5:0] EX_SLTU  = 6'd17;
  localparam logic [5:0] EX_SLTIU = 6'd18;
  localparam logic [5:0] EX_LUI   = 6'd19;
  localparam logic [5:0] EX_AUIPC = 6'd20;
  localparam logic [5:0] EX_LB    = 6'd21;
  localparam logic [5:0] EX_LH    = 6'd22;
  localparam logic [5:0] EX_LW    = 6'd23;
  localparam logic [5:0] EX_LBU   = 6'd24;
  localparam logic [5:0] EX_LHU   = 6'd25;
  localparam logic [5:0] EX_SB    = 6'd26;
  localparam logic [5:0] EX_SH    = 6'd27;
  localparam logic [5:0] EX_SW    = 6'd28;
  localparam logic [5:0] EX_MUL   = 6'd29;
  localparam logic [5:0] EX_MULH  = 6'd30;
  localparam logic [5:0] EX_DIV   = 6'd31;
  localparam logic [5:0] EX_REM   = 6'd32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/sb_fu_slot.sv
// One functional-unit slot: busy flag plus the rd it will write back.
// Latency: state updates at the accept/done edge. Backpressure: none; accept wins over done.
// Backpressure: a done pulse with the slot idle is ignored.
module sb_fu_slot #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_en,
  input  logic [REG_W-1:0] acc_rd,
  input  logic             done,
  output logic             busy,
  output logic             clear_en,
  output logic [REG_W-1:0] clear_rd
);

  logic [REG_W-1:0] held_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      held_rd <= '0;
    end else if (acc_en) begin
      busy    <= 1'b1;
      held_rd <= acc_rd;
    end else if (done) begin
      busy    <= 1'b0;
    end
  end

  assign clear_en = done & busy;
  assign clear_rd = held_rd;

endmodule

// File: rtl/scoreboard_issue.sv
// Issue stage: RAW/WAW/structural checks against a pending scoreboard; SB_DONE_BYPASS_EN lets done pulses unblock same-cycle.
// Latency: one cycle from accept to the iss_*_valid pulse.
// Backpressure: id_ready drops combinationally on any hazard; decode holds the instruction.
module scoreboard_issue
  import sb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int EXT_W    = 6,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_alu,
  input  logic                id_mul,
  input  logic                id_lsu,
  input  logic                id_store,
  input  logic                id_imm,
  input  logic [EXT_W-1:0]    id_ex_type,
  output logic                iss_alu_valid,
  output logic                iss_mul_valid,
  output logic                iss_lsu_valid,
  output logic [EXT_W-1:0]    iss_ex_type,
  output logic [REG_W-1:0]    iss_rs1,
  output logic [REG_W-1:0]    iss_rs2,
  output logic [REG_W-1:0]    iss_rd,
  input  logic                alu_done,
  input  logic                mul_done,
  input  logic                lsu_done,
  output logic [NUM_REGS-1:0] reg_pending,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [NUM_REGS-1:0] pending, pend_eff, clr_mask, set_mask, pending_nxt;
  logic [NUM_FU-1:0]   fu_sel, fu_busy, fu_done, fu_acc, fu_clr_en, busy_eff;
  logic [REG_W-1:0]    fu_clr_rd [NUM_FU];
  logic [REG_W-1:0]    slot_rd;
  logic                is_load, writes_rd, raw_hz, waw_hz, struct_hz, accept;

  assign fu_sel  = {id_lsu, id_mul, id_alu};
  assign fu_done = {lsu_done, mul_done, alu_done};
  assign slot_rd = id_store ? '0 : id_rd;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
    sb_fu_slot #(.REG_W(REG_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .acc_en   (fu_acc[g]),
      .acc_rd   (slot_rd),
      .done     (fu_done[g]),
      .busy     (fu_busy[g]),
      .clear_en (fu_clr_en[g]),
      .clear_rd (fu_clr_rd[g])
    );
  end

  always_comb begin
    clr_mask = '0;
    for (int g = 0; g < NUM_FU; g++) begin
      if (fu_clr_en[g]) clr_mask[fu_clr_rd[g]] = 1'b1;
    end
  end

`ifdef SB_DONE_BYPASS_EN
  assign pend_eff = pending & ~clr_mask;
  assign busy_eff = fu_busy & ~fu_done;
`else
  assign pend_eff = pending;
  assign busy_eff = fu_busy;
`endif

  // Loads read only rs1; stores read both sources but never write rd.
  always_comb begin
    is_load   = id_lsu & ~id_store;
    writes_rd = (|fu_sel) & ~id_store & (id_rd != '0);
    raw_hz    = ((id_rs1 != '0) & pend_eff[id_rs1]) |
                (~id_imm & ~is_load & (id_rs2 != '0) & pend_eff[id_rs2]);
    waw_hz    = writes_rd & pend_eff[id_rd];
    struct_hz = |(fu_sel & busy_eff);
    id_ready  = ~(raw_hz | waw_hz | struct_hz);
    accept    = id_valid & id_ready;
    fu_acc    = fu_sel & {NUM_FU{accept}};
  end

  // Set applied after clear so a same-cycle re-issue to the same rd stays pending.
  always_comb begin
    set_mask = '0;
    if (accept & writes_rd) set_mask[id_rd] = 1'b1;
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending       <= '0;
      iss_alu_valid <= 1'b0;
      iss_mul_valid <= 1'b0;
      iss_lsu_valid <= 1'b0;
      iss_ex_type   <= '0;
      iss_rs1       <= '0;
      iss_rs2       <= '0;
      iss_rd        <= '0;
      stall_cnt     <= '0;
    end else begin
      pending       <= pending_nxt;
      iss_alu_valid <= fu_acc[FU_ALU];
      iss_mul_valid <= fu_acc[FU_MUL];
      iss_lsu_valid <= fu_acc[FU_LSU];
      if (|fu_acc) begin
        iss_ex_type <= id_ex_type;
        iss_rs1     <= id_rs1;
        iss_rs2     <= id_rs2;
        iss_rd      <= id_rd;
      end
      if (id_valid & ~id_ready & (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign reg_pending = pending;

endmodule

// File: tb/tb_scoreboard_issue.sv
// Directed bench for scoreboard_issue with a cycle-level reference model; honours SB_DONE_BYPASS_EN.
module tb_scoreboard_issue;

  localparam int CW = 4;
  localparam logic [2:0] M_ALU = 3'b001;
  localparam logic [2:0] M_MUL = 3'b010;
  localparam logic [2:0] M_LSU = 3'b100;
`ifdef SB_DONE_BYPASS_EN
  localparam int BP = 1;
`else
  localparam int BP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 1'b0, id_ready;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic id_alu = 1'b0, id_mul = 1'b0, id_lsu = 1'b0, id_store = 1'b0, id_imm = 1'b0;
  logic [5:0] id_ex_type = '0;
  logic iss_alu_valid, iss_mul_valid, iss_lsu_valid;
  logic [5:0] iss_ex_type;
  logic [4:0] iss_rs1, iss_rs2, iss_rd;
  logic alu_done = 1'b0, mul_done = 1'b0, lsu_done = 1'b0;
  logic [31:0] reg_pending;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  scoreboard_issue #(.NUM_REGS(32), .REG_W(5), .EXT_W(6), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu(id_alu), .id_mul(id_mul), .id_lsu(id_lsu), .id_store(id_store), .id_imm(id_imm),
    .id_ex_type(id_ex_type),
    .iss_alu_valid(iss_alu_valid), .iss_mul_valid(iss_mul_valid), .iss_lsu_valid(iss_lsu_valid),
    .iss_ex_type(iss_ex_type), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .alu_done(alu_done), .mul_done(mul_done), .lsu_done(lsu_done),
    .reg_pending(reg_pending), .stall_cnt(stall_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  logic go = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view (pending set, per-FU owner) from the issue rules.
  logic [31:0] m_pend = '0;
  logic        m_busy [3] = '{1'b0, 1'b0, 1'b0};
  logic [4:0]  m_own  [3] = '{5'd0, 5'd0, 5'd0};
  logic [2:0]  m_iss = '0;
  logic [5:0]  m_ex = '0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  int          m_stall = 0;

  function automatic int sel_fu();
    if (id_alu) return 0;
    if (id_mul) return 1;
    if (id_lsu) return 2;
    return -1;
  endfunction

  function automatic logic m_ready();
    logic [31:0] p = m_pend;
    logic [2:0] d = {lsu_done, mul_done, alu_done};
    int f = sel_fu();
    logic uses_rs2, wr, hz;
    if (BP == 1)
      for (int i = 0; i < 3; i++) if (d[i] && m_busy[i]) p[m_own[i]] = 1'b0;
    uses_rs2 = !id_imm && !(id_lsu && !id_store);
    wr = (f >= 0) && !id_store && (id_rd != 0);
    hz = (id_rs1 != 0 && p[id_rs1]) || (uses_rs2 && id_rs2 != 0 && p[id_rs2]) || (wr && p[id_rd]);
    if (f >= 0 && m_busy[f] && !(BP == 1 && d[f])) hz = 1'b1;
    return !hz;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_pend = '0; m_iss = '0; m_ex = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_stall = 0;
      for (int i = 0; i < 3; i++) begin m_busy[i] = 1'b0; m_own[i] = '0; end
    end else begin
      logic rdy;
      logic [2:0] d;
      int f;
      rdy = m_ready();
      d = {lsu_done, mul_done, alu_done};
      f = sel_fu();
      if (id_valid && !rdy && m_stall < (1 << CW) - 1) m_stall++;
      for (int i = 0; i < 3; i++)
        if (d[i] && m_busy[i]) begin m_busy[i] = 1'b0; m_pend[m_own[i]] = 1'b0; end
      m_iss = '0;
      if (id_valid && rdy && f >= 0) begin
        m_busy[f] = 1'b1;
        m_own[f]  = id_store ? 5'd0 : id_rd;
        if (!id_store && id_rd != 0) m_pend[id_rd] = 1'b1;
        m_iss[f] = 1'b1;
        m_ex = id_ex_type; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (go) begin
      chk("id_ready", id_ready, m_ready());
      chk("iss_valid", {iss_lsu_valid, iss_mul_valid, iss_alu_valid}, m_iss);
      chk("iss_fields", {iss_ex_type, iss_rs1, iss_rs2, iss_rd}, {m_ex, m_rs1, m_rs2, m_rd});
      chk("reg_pending", reg_pending, m_pend);
      chk("stall_cnt", stall_cnt, m_stall[CW-1:0]);
    end
  end

  typedef struct packed {
    logic alu, mul, lsu, store, imm;
    logic [4:0] rs1, rs2, rd;
    logic [5:0] ex;
  } instr_t;

  function automatic instr_t mk(input logic a, m, l, s, i, input logic [4:0] r1, r2, d,
                                input logic [5:0] e);
    instr_t t;
    t.alu = a; t.mul = m; t.lsu = l; t.store = s; t.imm = i;
    t.rs1 = r1; t.rs2 = r2; t.rd = d; t.ex = e;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    alu_done = 1'b0; mul_done = 1'b0; lsu_done = 1'b0;
  endtask

  task automatic done_pulse(input logic [2:0] mask);
    {lsu_done, mul_done, alu_done} = mask;
    tick();
  endtask

  // Holds the instruction until accepted; returns the number of stalled cycles.
  task automatic issue(input instr_t t, input int done_at, input logic [2:0] mask, output int waited);
    logic acc;
    id_alu = t.alu; id_mul = t.mul; id_lsu = t.lsu; id_store = t.store; id_imm = t.imm;
    id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd; id_ex_type = t.ex;
    id_valid = 1'b1;
    waited = -1;
    for (int w = 0; w <= 40; w++) begin
      if (w == done_at) {lsu_done, mul_done, alu_done} = mask;
      @(negedge clk);
      acc = id_ready;
      tick();
      if (acc) begin waited = w; break; end
    end
    if (waited < 0) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: instruction rd=%0d never accepted", t.rd);
    end
    id_valid = 1'b0;
  endtask

  int w;

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); #1;
    go = 1'b1;
    chk("rst_ready", id_ready, 1);
    chk("rst_pending", reg_pending, 0);
    chk("rst_iss", {iss_lsu_valid, iss_mul_valid, iss_alu_valid}, 0);
    chk("rst_stall", stall_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // RAW: add x3,x1,x2 then addi x4,x3,1
    issue(mk(1,0,0,0,0, 5'd1, 5'd2, 5'd3, 6'd0), -1, 0, w);
    chk("add_wait", w, 0);
    chk("add_iss", {iss_alu_valid, iss_rd, iss_ex_type}, {1'b1, 5'd3, 6'd0});
    chk("add_pend", reg_pending, 32'h8);
    issue(mk(1,0,0,0,1, 5'd3, 5'd0, 5'd4, 6'd1), 1, M_ALU, w);
    chk("raw_wait", w, BP ? 1 : 2);
    chk("raw_stall_cnt", stall_cnt, BP ? 1 : 2);
    chk("addi_iss", {iss_alu_valid, iss_ex_type, iss_rs1, iss_rd}, {1'b1, 6'd1, 5'd3, 5'd4});
    chk("addi_pend", reg_pending, 32'h10);
    done_pulse(M_ALU);
    chk("clr_pend", reg_pending, 0);

    // Parallel FUs
    issue(mk(0,1,0,0,0, 5'd1, 5'd2, 5'd5, 6'd29), -1, 0, w);
    chk("mul_iss", {iss_lsu_valid, iss_mul_valid, iss_alu_valid, w[3:0]}, {3'b010, 4'd0});
    issue(mk(1,0,0,0,0, 5'd1, 5'd2, 5'd6, 6'd0), -1, 0, w);
    chk("par_iss", {iss_lsu_valid, iss_mul_valid, iss_alu_valid, w[3:0]}, {3'b001, 4'd0});
    chk("par_pend", reg_pending, 32'h60);
    done_pulse(M_ALU | M_MUL);
    chk("par_clr", reg_pending, 0);

    // WAW on x7, rd=x0, store rs2 hazard, load ignores rs2
    issue(mk(0,0,1,0,1, 5'd1, 5'd0, 5'd7, 6'd23), -1, 0, w);
    chk("lw_pend", reg_pending, 32'h80);
    issue(mk(1,0,0,0,0, 5'd1, 5'd2, 5'd7, 6'd0), 2, M_LSU, w);
    chk("waw_wait", w, BP ? 2 : 3);
    chk("waw_pend", reg_pending, 32'h80);
    done_pulse(M_ALU);
    issue(mk(1,0,0,0,0, 5'd1, 5'd2, 5'd0, 6'd0), -1, 0, w);
    chk("x0_wait", w, 0);
    chk("x0_pend", reg_pending, 0);
    done_pulse(M_ALU);
    issue(mk(0,1,0,0,0, 5'd1, 5'd2, 5'd7, 6'd29), -1, 0, w);
    issue(mk(0,0,1,1,0, 5'd1, 5'd7, 5'd5, 6'd28), 1, M_MUL, w);
    chk("sw_wait", w, BP ? 1 : 2);
    chk("sw_iss", {iss_lsu_valid, iss_mul_valid, iss_alu_valid}, 3'b100);
    chk("sw_pend", reg_pending, 0);
    done_pulse(M_LSU);
    issue(mk(0,1,0,0,0, 5'd1, 5'd2, 5'd7, 6'd29), -1, 0, w);
    issue(mk(0,0,1,0,0, 5'd1, 5'd7, 5'd9, 6'd23), -1, 0, w);
    chk("lw_rs2_wait", w, 0);
    chk("lw_rs2_pend", reg_pending, 32'h280);
    done_pulse(M_LSU | M_MUL);

    // Same-FU completion and accept
    issue(mk(1,0,0,0,0, 5'd1, 5'd2, 5'd10, 6'd0), -1, 0, w);
    issue(mk(1,0,0,0,0, 5'd1, 5'd2, 5'd11, 6'd0), 0, M_ALU, w);
    chk("same_fu_wait", w, BP ? 0 : 1);
    chk("same_fu_pend", reg_pending, 32'h800);
    done_pulse(M_ALU);

    // Done and accept on the same rd
    issue(mk(0,1,0,0,0, 5'd1, 5'd2, 5'd8, 6'd29), -1, 0, w);
    issue(mk(1,0,0,0,0, 5'd1, 5'd2, 5'd8, 6'd0), 0, M_MUL, w);
    chk("same_rd_wait", w, BP ? 0 : 1);
    chk("same_rd_pend", reg_pending, 32'h100);

    // No-FU instruction waits only for rs1 and issues nothing
    issue(mk(0,0,0,0,0, 5'd8, 5'd0, 5'd13, 6'd0), 1, M_ALU, w);
    chk("nofu_wait", w, BP ? 1 : 2);
    chk("nofu_iss", {iss_lsu_valid, iss_mul_valid, iss_alu_valid}, 3'b000);
    chk("nofu_pend", reg_pending, 0);

    // Long stall saturates the counter
    issue(mk(1,0,0,0,0, 5'd1, 5'd2, 5'd20, 6'd0), -1, 0, w);
    issue(mk(1,0,0,0,1, 5'd20, 5'd0, 5'd21, 6'd1), 20, M_ALU, w);
    chk("sat_wait", w, BP ? 20 : 21);
    chk("sat_cnt", stall_cnt, 4'hF);
    done_pulse(M_ALU);

    // Reset mid-operation; stale done is ignored
    issue(mk(0,1,0,0,0, 5'd1, 5'd2, 5'd5, 6'd29), -1, 0, w);
    chk("pre_rst_pend", reg_pending, 32'h20);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", id_ready, 1);
    chk("mid_rst_pend", reg_pending, 0);
    chk("mid_rst_iss", {iss_lsu_valid, iss_mul_valid, iss_alu_valid, iss_ex_type, iss_rd}, 0);
    chk("mid_rst_cnt", stall_cnt, 0);
    tick();
    rst = 1'b0;
    done_pulse(M_MUL);
    chk("stale_done_pend", reg_pending, 0);
    issue(mk(0,1,0,0,0, 5'd1, 5'd2, 5'd6, 6'd29), -1, 0, w);
    chk("post_rst_wait", w, 0);
    chk("post_rst_pend", reg_pending, 32'h40);

    tick();
    go = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scoreboard_issue.md
Name: scoreboard_issue

Overview:
- Issue stage directly downstream of instruction decode in the scoreboard RISC-V core.
- Takes one decoded instruction per cycle: register indices, FU-class flags (alu/mul/lsu), store flag and 6-bit ex_type.
- Checks RAW, WAW and structural hazards against a register-pending scoreboard and per-FU busy flags.
- Issues the instruction to exactly one functional unit, or stalls decode via a valid/ready handshake.

Parameters:
- NUM_REGS, 32, number of architectural integer registers.
- REG_W, 5, register index width.
- EXT_W, 6, ex_type width.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- id_valid  in  1  decode holds a valid instruction
- id_ready  out  1  issue accepts this cycle; transfer = id_valid & id_ready
- id_rs1, id_rs2, id_rd  in  REG_W each  source and destination indices
- id_alu, id_mul, id_lsu  in  1 each  FU class; at most one set
- id_store  in  1  store; no rd write
- id_imm  in  1  rs2 unused (immediate form)
- id_ex_type  in  EXT_W  operation code
- iss_alu_valid, iss_mul_valid, iss_lsu_valid  out  1 each  one-cycle issue pulse to the FU
- iss_ex_type  out  EXT_W  registered operation
- iss_rs1, iss_rs2, iss_rd  out  REG_W each  registered indices
- alu_done, mul_done, lsu_done  in  1 each  FU completion/writeback pulse
- reg_pending  out  NUM_REGS  scoreboard vector (bit 0 always 0)
- stall_cnt  out  CNT_W  cycles with id_valid & ~id_ready, saturating

Behaviour:
- Reset (async, rst=1): pending=0, all FU busy=0, held rd=0, iss_* all 0, stall_cnt=0. id_ready is combinational and therefore reads 1 during reset.
- Hazards, evaluated on registered state only:
  - raw = pending[rs1] | (~id_imm & ~id_lsu_load & pending[rs2]). Loads use only rs1; stores use rs1 and rs2.
  - waw = writes_rd & pending[rd], where writes_rd = (alu|mul|lsu) & ~id_store & (rd!=0).
  - struct = busy of the selected FU.
- Handshake:
  - id_ready = ~(raw | waw | struct).
  - Instructions with no FU flag (jal/branch/ecall, handled elsewhere) need only ~raw. They set nothing and pulse no iss_*.
- Accept at edge N:
  - Selected FU busy=1; FU slot stores rd (0 when a store).
  - pending[rd]=1 if writes_rd.
  - Registered issue outputs update; exactly one iss_*_valid=1 during cycle N+1. Latency = 1 cycle.
  - iss_*_valid returns to 0 the next cycle unless another accept occurs.
- Completion: X_done at edge clears busy[X] and pending[held_rd[X]]. A done pulse while the FU is not busy is ignored.
- Simultaneous done and accept:
  - Different registers: both take effect.
  - Same register: the set (new pending) wins over the clear.
- Same-FU done and accept in the same cycle: the accept is blocked (struct uses the registered busy). This costs one bubble; see Optional Feature.
- Register x0 is never pending; rs==0 never hazards.
- Reset mid-operation clears all state; FU done pulses arriving after reset are ignored.
- stall_cnt increments when id_valid & ~id_ready and saturates at all-ones.

Optional Feature:
- Macro: SB_DONE_BYPASS_EN.
- Defined:
  - struct = busy[X] & ~X_done.
  - raw/waw also ignore the register being cleared this cycle by any done pulse.
  - Back-to-back reuse of an FU has zero bubbles.
- Undefined: hazards use registered state only; one bubble after each completion. This adds no combinational done→ready path.

Decomposition:
- Package sb_pkg:
  - FU index constants FU_ALU=0, FU_MUL=1, FU_LSU=2.
  - ex_type localparams 0..32, e.g. EX_ADD=0, EX_LW=23, EX_MUL=29.
  - Opcode constants.
- Sub-module sb_fu_slot, instantiated three times: busy flag, held rd, accept/done logic, outputs busy and clear_rd/clear_en.

Test Plan:
1. Reset: assert rst mid-run -> iss_* =0, reg_pending=0, stall_cnt=0, id_ready=1 with id_valid low.
2. RAW: add x3,x1,x2 then addi x4,x3,1 -> add issues in cycle 1. addi stalls, stall_cnt counts, until alu_done. addi issues the cycle after done (bypass undefined) with iss_ex_type=1.
3. Parallel FUs: mul x5,x1,x2 then add x6,x1,x2 -> iss_mul_valid and iss_alu_valid in consecutive cycles; reg_pending bits 5 and 6 set.
4. WAW and x0: lw x7 then add x7,x1,x2 -> stall until lsu_done. add x0,x1,x2 -> pending stays 0. sw x7,0(x1) with x7 pending -> stalls (rs2 read).
5. Same-FU completion: alu busy, alu_done and a new add in the same cycle -> undefined: issue one cycle later. With SB_DONE_BYPASS_EN: issue immediately with no bubble.
6. Done/accept same rd: mul x8 done while add x8 accepted (bypass on) -> reg_pending[8]=1 after the edge.
